// File: rtl/servo_slew_pwm_pkg.sv
`default_nettype none
// ============================================================================
// servo_pkg: widths, state encoding and shared arm positions for servo_slew_pwm.
// Rev 1.0
// ============================================================================
package servo_pkg;

  localparam int POS_W = 20;
  localparam int CNT_W = 21;

  localparam int unsigned FRAME_LEN_DEFAULT  = 2000000;
  localparam int unsigned BASE_PULSE_DEFAULT = 50000;

  typedef enum logic [1:0] {
    SLEW      = 2'd0,
    SETTLE    = 2'd1,
    AT_TARGET = 2'd2
  } servo_state_e;

  // Arm poses shared with the sequencer, in cycles above the base pulse.
  localparam logic [POS_W-1:0] CLAW_OPEN     = 20'd113274;
  localparam logic [POS_W-1:0] CLAW_CLOSE    = 20'd199218;
  localparam logic [POS_W-1:0] UPPER_PICKUP  = 20'd60000;
  localparam logic [POS_W-1:0] UPPER_DROPOFF = 20'd150000;
  localparam logic [POS_W-1:0] LOWER_PICKUP  = 20'd90000;
  localparam logic [POS_W-1:0] LOWER_DROPOFF = 20'd40000;

  function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] req,
                                                 input logic [POS_W-1:0] lim);
    return (req > lim) ? lim : req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/servo_slew_pwm_frame_timer.sv
`default_nettype none
// ============================================================================
// servo_frame_timer: free-running 0..FRAME_LEN-1 counter with end-of-frame tick.
// Rev 1.0
// ============================================================================
module servo_frame_timer
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  output logic [CNT_W-1:0] count,
  output logic             tick
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_count <= '0;
    end else if (r_count == c_LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
  assign tick  = (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/servo_slew_pwm.sv
`default_nettype none
// ============================================================================
// servo_slew_pwm: per-joint servo PWM driver with target tracking and settle FLAG.
// Rev 1.0 -- define SERVO_SLEW_EN for STEP-limited motion; otherwise POS jumps.
// ============================================================================
module servo_slew_pwm
  import servo_pkg::*;
#(
  parameter int unsigned FRAME_LEN     = FRAME_LEN_DEFAULT,
  parameter int unsigned BASE_PULSE    = BASE_PULSE_DEFAULT,
  parameter int unsigned MAX_POS       = 200000,
  parameter int unsigned STEP          = 4000,
  parameter int unsigned SETTLE_FRAMES = 3,
  parameter int unsigned INIT_POS      = 113274
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [POS_W-1:0] DESIRED,
  output logic             PWM,
  output logic             FLAG,
  output logic [POS_W-1:0] POS
);

  localparam logic [1:0] c_ST_SLEW      = SLEW;
  localparam logic [1:0] c_ST_SETTLE    = SETTLE;
  localparam logic [1:0] c_ST_AT_TARGET = AT_TARGET;

  localparam int c_WW    = CNT_W + 1;
  localparam int c_SET_W = (SETTLE_FRAMES > 1) ? $clog2(SETTLE_FRAMES) : 1;

  localparam logic [c_SET_W-1:0] c_SETTLE_LAST = c_SET_W'(SETTLE_FRAMES - 1);
  localparam logic [POS_W-1:0]   c_MAX_POS     = POS_W'(MAX_POS);
  localparam logic [POS_W-1:0]   c_INIT_POS    = POS_W'(INIT_POS);
  localparam logic [c_WW-1:0]    c_BASE        = c_WW'(BASE_PULSE);

  if ((SETTLE_FRAMES < 1) || (STEP < 1) || (MAX_POS >= (1 << POS_W)) ||
      (INIT_POS > MAX_POS)) begin : g_param_check
    $error("servo_slew_pwm: illegal parameter set");
  end

  logic [CNT_W-1:0]   w_count;
  logic               w_tick;
  logic [POS_W-1:0]   w_clamp;
  logic               w_capture;
  logic [POS_W-1:0]   w_next_pos;
  logic [c_WW-1:0]    w_width;

  logic [POS_W-1:0]   r_pos;
  logic [POS_W-1:0]   r_target;
  logic [1:0]         r_state;
  logic [c_SET_W-1:0] r_settle;
  logic               r_flag;
  logic               r_pwm;

  servo_frame_timer #(
    .FRAME_LEN (FRAME_LEN)
  ) u_timer (
    .CLK   (CLK),
    .RST   (RST),
    .count (w_count),
    .tick  (w_tick)
  );

  assign w_clamp   = clamp_pos(DESIRED, c_MAX_POS);
  assign w_capture = (w_clamp != r_target);
  assign w_width   = c_BASE + {2'b00, r_pos};

`ifdef SERVO_SLEW_EN
  localparam logic [POS_W-1:0] c_STEP = POS_W'(STEP);

  logic [POS_W:0]   w_diff;
  logic             w_up;
  logic [POS_W-1:0] w_dist;

  // Sign bit of the 21-bit difference gives the direction of travel.
  assign w_diff = {1'b0, r_target} - {1'b0, r_pos};
  assign w_up   = ~w_diff[POS_W];
  assign w_dist = w_up ? w_diff[POS_W-1:0] : (r_pos - r_target);

  always_comb begin
    w_next_pos = r_target;
    if (w_dist > c_STEP) begin
      w_next_pos = w_up ? (r_pos + c_STEP) : (r_pos - c_STEP);
    end
  end
`else
  assign w_next_pos = r_target;
`endif

  // Compare uses the pre-update POS, so a whole frame always sees one width.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= ({1'b0, w_count} < w_width);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_pos    <= c_INIT_POS;
      r_target <= c_INIT_POS;
      r_state  <= c_ST_SETTLE;
      r_settle <= '0;
      r_flag   <= 1'b0;
    end else if (w_capture) begin
      // A new request pre-empts any tick arriving in the same cycle.
      r_target <= w_clamp;
      r_state  <= c_ST_SLEW;
      r_settle <= '0;
      r_flag   <= 1'b0;
    end else if (w_tick) begin
      case (r_state)
        c_ST_SLEW: begin
          r_pos <= w_next_pos;
          if (w_next_pos == r_target) begin
            r_state  <= c_ST_SETTLE;
            r_settle <= '0;
          end
        end
        c_ST_SETTLE: begin
          if (r_settle == c_SETTLE_LAST) begin
            r_state <= c_ST_AT_TARGET;
            r_flag  <= 1'b1;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        c_ST_AT_TARGET: begin
          r_state <= c_ST_AT_TARGET;
        end
        default: begin
          r_state  <= c_ST_SETTLE;
          r_settle <= '0;
        end
      endcase
    end
  end

  assign PWM  = r_pwm;
  assign FLAG = r_flag;
  assign POS  = r_pos;

endmodule
`default_nettype wire

// File: tb/tb_servo_slew_pwm.sv
`default_nettype none
// tb_servo_slew_pwm: scaled-down frame; per-cycle reference model plus directed
// vectors and sequences for servo_slew_pwm.
module tb_servo_slew_pwm;

  localparam int FL     = 420;
  localparam int BASE   = 40;
  localparam int MAXP   = 340;
  localparam int STEP   = 40;
  localparam int SETTLE = 3;
  localparam int INIT   = 113;
`ifdef SERVO_SLEW_EN
  localparam bit SLEW_ON = 1'b1;
`else
  localparam bit SLEW_ON = 1'b0;
`endif

  typedef struct {
    int desired;
    int exp_pos;
    int exp_pulse;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [19:0] desired = 20'(INIT);
  logic        pwm;
  logic        flag;
  logic [19:0] pos;

  servo_slew_pwm #(
    .FRAME_LEN     (FL),
    .BASE_PULSE    (BASE),
    .MAX_POS       (MAXP),
    .STEP          (STEP),
    .SETTLE_FRAMES (SETTLE),
    .INIT_POS      (INIT)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .DESIRED (desired),
    .PWM     (pwm),
    .FLAG    (flag),
    .POS     (pos)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame phase, target, position, ticks spent at target.
  int m_cnt, m_pos, m_tgt, m_since;
  bit m_moving, m_pwm, m_flag;

  function automatic int step_toward(input int p, input int t);
    if (!SLEW_ON || ((t - p) <= STEP && (p - t) <= STEP)) return t;
    return (t > p) ? p + STEP : p - STEP;
  endfunction

  always @(posedge clk) begin
    int cl;
    bit tick;
    if (rst) begin
      m_cnt = 0; m_pos = INIT; m_tgt = INIT; m_since = 0;
      m_moving = 0; m_pwm = 0; m_flag = 0;
    end else begin
      cl   = (int'(desired) > MAXP) ? MAXP : int'(desired);
      tick = (m_cnt == FL - 1);
      m_pwm = (m_cnt < BASE + m_pos);
      if (cl != m_tgt) begin
        m_tgt = cl; m_moving = 1; m_since = 0; m_flag = 0;
      end else if (tick) begin
        if (m_moving) begin
          m_pos    = step_toward(m_pos, m_tgt);
          m_moving = (m_pos != m_tgt);
          m_since  = 0;
        end else if (!m_flag) begin
          m_since++;
          m_flag = (m_since >= SETTLE);
        end
      end
      m_cnt = tick ? 0 : m_cnt + 1;
    end
  end

  bit sb_en = 0;
  int max_pos_seen = 0;

  always @(negedge clk) begin
    if (sb_en) begin
      check("scoreboard {pwm,flag,pos}", {pwm, flag, pos}, {m_pwm, m_flag, 20'(m_pos)});
      if (int'(pos) > max_pos_seen) max_pos_seen = int'(pos);
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_flag(input string name, input int budget);
    int n;
    n = 0;
    while (!flag && n < budget) begin @(negedge clk); n++; end
    check({name, " flag within budget"}, flag, 1);
  endtask

  task automatic wait_phase(input int phase);
    int n;
    n = 0;
    while (m_cnt != phase && n < 2 * FL) begin @(negedge clk); n++; end
    check("frame phase reached", m_cnt, phase);
  endtask

  task automatic measure_pulse(output int width);
    int n;
    n = 0;
    width = 0;
    while (pwm && n < 2 * FL) begin @(negedge clk); n++; end
    while (!pwm && n < 4 * FL) begin @(negedge clk); n++; end
    while (pwm && width < FL) begin @(negedge clk); width++; end
  endtask

  initial begin
    vec_t vecs[5];
    int w, n, changes, prev, first_new;
    bit flag_seen;

    vecs[0] = '{600, 340, 380};
    vecs[1] = '{0, 0, 40};
    vecs[2] = '{1048575, 340, 380};
    vecs[3] = '{250, 250, 290};
    vecs[4] = '{113, 113, 153};

    // Reset with target held at INIT: pulse width and settle latency.
    rst = 1'b1;
    desired = 20'(INIT);
    cycles(3);
    sb_en = 1;
    check("reset pwm", pwm, 0);
    check("reset flag", flag, 0);
    check("reset pos", pos, INIT);
    rst = 1'b0;
    n = 0;
    while (!flag && n < 4 * FL) begin @(negedge clk); n++; end
    check("flag latency after reset", n, SETTLE * FL);
    check("pos held at init", pos, INIT);
    measure_pulse(w);
    check("init pulse width", w, BASE + INIT);

    // Step request: flag drops next cycle, motion in STEP increments, settle.
    desired = 20'd313;
    @(negedge clk);
    check("flag drops after capture", flag, 0);
    prev = int'(pos); changes = 0; n = 0;
    while (pos != 20'd313 && n < 8 * FL) begin
      @(negedge clk); n++;
      if (int'(pos) != prev) begin changes++; prev = int'(pos); end
    end
    check("ticks to reach 313", changes, SLEW_ON ? 5 : 1);
    n = 0;
    while (!flag && n < 4 * FL) begin @(negedge clk); n++; end
    check("flag latency after reach", n, SETTLE * FL);
    measure_pulse(w);
    check("pulse at 313", w, BASE + 313);

    // Table: clamp and boundary positions.
    for (int i = 0; i < 5; i++) begin
      desired = 20'(vecs[i].desired);
      @(negedge clk);
      wait_flag($sformatf("vec%0d", i), 14 * FL);
      check($sformatf("vec%0d pos", i), pos, vecs[i].exp_pos);
      measure_pulse(w);
      check($sformatf("vec%0d pulse", i), w, vecs[i].exp_pulse);
    end
    check("pos never above MAX_POS", max_pos_seen > MAXP, 0);

    // Reverse mid-slew.
    desired = 20'd313;
    @(negedge clk);
    prev = int'(pos); changes = 0; n = 0;
    while (changes < (SLEW_ON ? 2 : 1) && n < 4 * FL) begin
      @(negedge clk); n++;
      if (int'(pos) != prev) begin changes++; prev = int'(pos); end
    end
    check("pos before reversal", pos, SLEW_ON ? 193 : 313);
    desired = 20'(INIT);
    changes = 0; n = 0; flag_seen = 0; first_new = -1;
    while (pos != 20'(INIT) && n < 8 * FL) begin
      @(negedge clk); n++;
      if (flag) flag_seen = 1;
      if (int'(pos) != prev) begin
        if (first_new < 0) first_new = int'(pos);
        changes++; prev = int'(pos);
      end
    end
    check("first pos after reversal", first_new, SLEW_ON ? 153 : INIT);
    check("ticks back to init", changes, SLEW_ON ? 2 : 1);
    check("flag low during reversal", flag_seen, 0);
    wait_flag("after reversal", 6 * FL);

    // Capture on the same edge as a tick: no move that tick.
    wait_phase(FL - 1);
    desired = 20'd273;
    @(negedge clk);
    check("no move on capture tick", pos, INIT);
    check("flag low on capture tick", flag, 0);
    cycles(FL - 1);
    check("pos held until next tick", pos, INIT);
    cycles(1);
    check("pos moves next tick", pos, SLEW_ON ? 153 : 273);

    // Reset mid-pulse.
    desired = 20'(INIT);
    @(negedge clk);
    wait_flag("before reset", 14 * FL);
    wait_phase(20);
    check("pwm high mid-pulse", pwm, 1);
    rst = 1'b1;
    @(negedge clk);
    check("pwm cut by reset", pwm, 0);
    check("pos after mid reset", pos, INIT);
    check("flag after mid reset", flag, 0);
    rst = 1'b0;
    @(negedge clk);
    n = 1;
    check("pwm restarts after reset", pwm, 1);
    while (pwm && n < FL) begin @(negedge clk); n++; end
    check("first pulse after reset", n, BASE + INIT + 1);

    // Random requests against the model.
    for (int i = 0; i < 25; i++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) desired = 20'($urandom);
      else if (r == 1) desired = pos;
      else desired = 20'($urandom_range(0, MAXP + 60));
      cycles(int'($urandom_range(1, 3 * FL)));
    end
    check("pos never above MAX_POS (random)", max_pos_seen > MAXP, 0);

    sb_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
